// File: rtl/sm3_pkg.sv
// Shared SM3 constants and the message sequencer state encoding.
// Imported by the sequencer and its surroundings.
package sm3_pkg;

  localparam int BLK_W = 512;
  localparam int DIG_W = 256;

  localparam logic [DIG_W-1:0] SM3_IV =
    256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/sm3_msg_seq.sv
// Multi-block SM3 message sequencer: feeds blocks and chaining values to an
// external compression core and returns the final digest on a valid/ready port.
module sm3_msg_seq
  import sm3_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_blk_valid,
  output logic              o_blk_ready,
  input  logic [BLK_W-1:0]  i_blk_data,
  input  logic              i_blk_last,
  output logic              o_hash_valid,
  input  logic              i_hash_ready,
  output logic [DIG_W-1:0]  o_hash,
  output logic              o_core_start,
  output logic [BLK_W-1:0]  o_core_data,
  output logic [DIG_W-1:0]  o_core_vin,
  input  logic [DIG_W-1:0]  i_core_vout,
  input  logic              i_core_done,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_blk_cnt,
  output logic              o_err
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

  seq_state_e        state;
  seq_state_e        state_nxt;
  logic              first;
  logic              last;
  logic [DIG_W-1:0]  chain;
  logic [WD_W-1:0]   wdog;
  logic              accept;
  logic              done_ok;
  logic              timeout;
  logic              hash_take;

  // Next-state decode and per-state events
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done_ok   = 1'b0;
    timeout   = 1'b0;
    hash_take = 1'b0;
    case (state)
      ST_IDLE: begin
        accept = i_blk_valid & o_blk_ready;
        if (accept) state_nxt = ST_START;
        else        state_nxt = ST_IDLE;
      end
      ST_START: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (i_core_done) begin
          done_ok   = 1'b1;
          state_nxt = last ? ST_OUT : ST_IDLE;
        end else if (wdog == WD_MAX) begin
          timeout   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      ST_OUT: begin
        hash_take = i_hash_ready;
        if (i_hash_ready) state_nxt = ST_IDLE;
        else              state_nxt = ST_OUT;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register and handshake/status flags, decoded from the next state
  // so they line up with the state they describe
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      o_blk_ready  <= 1'b0;
      o_core_start <= 1'b0;
      o_hash_valid <= 1'b0;
      o_busy       <= 1'b0;
      wdog         <= '0;
    end else begin
      state        <= state_nxt;
      o_blk_ready  <= (state_nxt == ST_IDLE);
      o_core_start <= (state_nxt == ST_START);
      o_hash_valid <= (state_nxt == ST_OUT);
      o_busy       <= (state_nxt != ST_IDLE);
      wdog         <= (state == ST_WAIT) ? wdog + WD_W'(1) : '0;
    end
  end

  // Block capture, chaining, digest and message bookkeeping
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      first       <= 1'b1;
      last        <= 1'b0;
      chain       <= '0;
      o_hash      <= '0;
      o_core_data <= '0;
      o_core_vin  <= '0;
      o_blk_cnt   <= '0;
      o_err       <= 1'b0;
    end else begin
      if (accept) begin
        o_core_data <= i_blk_data;
        o_core_vin  <= first ? SM3_IV : chain;
        last        <= i_blk_last;
      end
      if (done_ok) begin
        chain <= i_core_vout;
        if (o_blk_cnt != {CNT_W{1'b1}}) o_blk_cnt <= o_blk_cnt + CNT_W'(1);
        if (last) o_hash <= i_core_vout;
        else      first  <= 1'b0;
      end
      // A timed-out message is abandoned; the next block starts a new one
      if (timeout) begin
        o_err     <= 1'b1;
        first     <= 1'b1;
        o_blk_cnt <= '0;
      end
      if (hash_take) begin
        first     <= 1'b1;
        o_blk_cnt <= '0;
      end
    end
  end

endmodule
